siso: RTL and testbench

SISO -- requirements
Module: siso

---
 rtl/siso.sv | 34 +++
 tb/tb_siso.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/siso.sv
// rtl/siso.sv - serial-in serial-out shift register with parallel stage view
module siso #(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  output logic             dout,
  output logic [DEPTH-1:0] q
);

  logic [DEPTH-1:0] stage;
  logic [DEPTH-1:0] stage_shifted;

  // stage[0] takes the newest bit; a single-stage register has nothing to shift along
  if (DEPTH == 1) begin : g_single
    assign stage_shifted = din;
  end else begin : g_chain
    assign stage_shifted = {stage[DEPTH-2:0], din};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage <= '0;
    end else if (en) begin
      stage <= stage_shifted;
    end
  end

  assign q    = stage;
  assign dout = stage[DEPTH-1];

endmodule

// File: tb/tb_siso.sv
// tb/tb_siso.sv - self-checking bench for siso at DEPTH 1, 4 and 8
module tb_siso;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic       din   = 1'b0;
  logic       dout1, dout4, dout8;
  logic [0:0] q1;
  logic [3:0] q4;
  logic [7:0] q8;

  always #5 clock = ~clock;

  siso #(.DEPTH(1)) dut1 (.clock(clock), .reset(reset), .en(en), .din(din), .dout(dout1), .q(q1));
  siso #(.DEPTH(4)) dut4 (.clock(clock), .reset(reset), .en(en), .din(din), .dout(dout4), .q(q4));
  siso #(.DEPTH(8)) dut8 (.clock(clock), .reset(reset), .en(en), .din(din), .dout(dout8), .q(q8));

  typedef struct {
    logic       reset;
    logic       en;
    logic       din;
    logic       exp_dout;
    logic [3:0] exp_q;
  } vec_t;

  typedef bit bq_t[$];

  vec_t vecs[$];
  bq_t  sb1, sb4, sb8;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: front of the queue is the oldest bit, i.e. the expected dout
  function automatic bq_t sb_step(input bq_t sb, input int depth, input logic r, input logic e, input logic d);
    bq_t s;
    s = sb;
    if (r) begin
      s.delete();
      for (int i = 0; i < depth; i++) s.push_back(1'b0);
    end else if (e) begin
      s.push_back(d);
      void'(s.pop_front());
    end
    return s;
  endfunction

  function automatic logic [7:0] sb_par(input bq_t sb, input int depth);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < depth; i++) p[i] = sb[depth-1-i];
    return p;
  endfunction

  task automatic add(input logic r, input logic e, input logic d, input logic o, input logic [3:0] qq);
    vec_t v;
    v.reset = r; v.en = e; v.din = d; v.exp_dout = o; v.exp_q = qq;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic r, input logic e, input logic d, input string tag);
    reset = r;
    en    = e;
    din   = d;
    sb1 = sb_step(sb1, 1, r, e, d);
    sb4 = sb_step(sb4, 4, r, e, d);
    sb8 = sb_step(sb8, 8, r, e, d);
    @(posedge clock);
    #1;
    check({tag, " d1 dout"}, {7'd0, dout1}, {7'd0, sb1[0]});
    check({tag, " d1 q"},    {7'd0, q1},    sb_par(sb1, 1));
    check({tag, " d8 dout"}, {7'd0, dout8}, {7'd0, sb8[0]});
    check({tag, " d8 q"},    q8,            sb_par(sb8, 8));
  endtask

  initial begin
    // reset, then stream 1,1,1,0,1,0,0,1 followed by zeros
    add(1, 1, 1, 0, 4'b0000);
    add(1, 0, 0, 0, 4'b0000);
    add(0, 1, 1, 0, 4'b0001);
    add(0, 1, 1, 0, 4'b0011);
    add(0, 1, 1, 0, 4'b0111);
    add(0, 1, 0, 1, 4'b1110);
    add(0, 1, 1, 1, 4'b1101);
    add(0, 1, 0, 1, 4'b1010);
    add(0, 1, 0, 0, 4'b0100);
    add(0, 1, 1, 1, 4'b1001);
    add(0, 1, 0, 0, 4'b0010);
    add(0, 1, 0, 0, 4'b0100);
    add(0, 1, 0, 1, 4'b1000);
    add(0, 1, 0, 0, 4'b0000);
    // parallel view after 1,0,1,1 (oldest bit in q[3])
    add(1, 0, 1, 0, 4'b0000);
    add(0, 1, 1, 0, 4'b0001);
    add(0, 1, 0, 0, 4'b0010);
    add(0, 1, 1, 0, 4'b0101);
    add(0, 1, 1, 1, 4'b1011);
    // hold for 5 edges with din toggling, then resume
    add(0, 0, 0, 1, 4'b1011);
    add(0, 0, 1, 1, 4'b1011);
    add(0, 0, 0, 1, 4'b1011);
    add(0, 0, 1, 1, 4'b1011);
    add(0, 0, 0, 1, 4'b1011);
    add(0, 1, 0, 0, 4'b0110);
    // four ones, then reset mid-stream with en=1 and din=1
    add(0, 1, 1, 1, 4'b1101);
    add(0, 1, 1, 1, 4'b1011);
    add(0, 1, 1, 0, 4'b0111);
    add(0, 1, 1, 1, 4'b1111);
    add(1, 1, 1, 0, 4'b0000);
    // next 1 reaches dout after 4 enabled edges, pauses not counted
    add(0, 1, 1, 0, 4'b0001);
    add(0, 1, 0, 0, 4'b0010);
    add(0, 0, 1, 0, 4'b0010);
    add(0, 0, 1, 0, 4'b0010);
    add(0, 1, 0, 0, 4'b0100);
    add(0, 1, 0, 1, 4'b1000);

    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].reset, vecs[i].en, vecs[i].din, $sformatf("vec%0d", i));
      check($sformatf("vec%0d d4 dout", i), {7'd0, dout4}, {7'd0, vecs[i].exp_dout});
      check($sformatf("vec%0d d4 q", i),    {4'd0, q4},    {4'd0, vecs[i].exp_q});
    end

    // reset pulse that never meets a rising edge must not disturb state
    reset = 1'b1;
    en    = 1'b0;
    #3;
    reset = 1'b0;
    apply(0, 0, 0, "midpulse");
    check("midpulse d4 q",    {4'd0, q4},    {4'd0, 4'b1000});
    check("midpulse d4 dout", {7'd0, dout4}, 8'd1);

    // random 64-bit stream with occasional pauses, all depths against the scoreboard
    apply(1, 0, 0, "rnd_rst");
    for (int i = 0; i < 72; i++) begin
      logic e, d;
      e = ($urandom_range(0, 3) != 0);
      d = (i < 64) ? 1'($urandom_range(0, 1)) : 1'b0;
      apply(0, e, d, $sformatf("rnd%0d", i));
      check($sformatf("rnd%0d d4 dout", i), {7'd0, dout4}, {7'd0, sb4[0]});
      check($sformatf("rnd%0d d4 q", i),    {4'd0, q4},    sb_par(sb4, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
